key_note_ctrl: RTL

Sequencer between the PS/2 byte receiver and the note lookup of the keyboard-piano datapath. Parses make/break/extended scan-code sequences, tracks up to DEPTH simultaneously held note keys with last-pressed priority, and drives the lookup's `keycode` input. Also provides a gate and a one-cycle change strobe to the tone generator. Typematic repeats and non-note keys are filtered out.

---
 rtl/key_note_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/key_note_ctrl.sv
// Scan-code sequencer for the keyboard piano: parses make/break/extended PS/2 bytes
// and keeps a last-pressed-priority stack of held note keys feeding the note lookup.
module key_note_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] data,
    input  logic       ready,
    output logic [7:0] keycode,
    output logic       note_on,
    output logic       note_change,
    output logic [3:0] held_cnt,
    output logic       overflow
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t     state_reg;
    logic [7:0] slot_reg  [DEPTH];
    logic [7:0] slot_next [DEPTH];
    logic [3:0] cnt_next;
    logic [7:0] keycode_next;

    logic             is_note;
    logic             do_press;
    logic             do_release;
    logic             present;
    logic             full;
    logic             press_shift;
    logic             rel_shift;
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] below_hit;

    always_comb begin
        is_note = 1'b0;
        case (data)
            8'h16, 8'h1E, 8'h26, 8'h25,
            8'h2E, 8'h36, 8'h3D, 8'h3E: is_note = 1'b1;
            default:                    is_note = 1'b0;
        endcase
    end

    assign do_press    = ready && (state_reg == IDLE) && is_note;
    assign do_release  = ready && (state_reg == BRK) && is_note;
    assign present     = |hit;
    assign full        = (held_cnt == 4'(DEPTH));
    assign press_shift = do_press && !present;
    assign rel_shift   = do_release && present;

    // below_hit marks the matching slot and everything older, i.e. the slots that move up on release
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign hit[gi] = (4'(gi) < held_cnt) && (slot_reg[gi] == data);

            if (gi == 0) begin : g_first
                assign below_hit[gi] = hit[gi];
            end else begin : g_rest
                assign below_hit[gi] = below_hit[gi-1] | hit[gi];
            end

            if (gi == 0) begin : g_top
                assign slot_next[gi] = press_shift ? data :
                                       (rel_shift && below_hit[gi]) ? slot_reg[gi+1] :
                                       slot_reg[gi];
            end else if (gi == DEPTH - 1) begin : g_bottom
                assign slot_next[gi] = press_shift ? slot_reg[gi-1] :
                                       (rel_shift && below_hit[gi]) ? 8'h00 :
                                       slot_reg[gi];
            end else begin : g_mid
                assign slot_next[gi] = press_shift ? slot_reg[gi-1] :
                                       (rel_shift && below_hit[gi]) ? slot_reg[gi+1] :
                                       slot_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        cnt_next = held_cnt;
        if (press_shift && !full)
            cnt_next = held_cnt + 4'd1;
        else if (rel_shift)
            cnt_next = held_cnt - 4'd1;
    end

    assign keycode_next = (cnt_next != 4'd0) ? slot_next[0] : 8'h00;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg   <= IDLE;
            for (int i = 0; i < DEPTH; i++)
                slot_reg[i] <= 8'h00;
            held_cnt    <= 4'd0;
            keycode     <= 8'h00;
            note_on     <= 1'b0;
            note_change <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (ready) begin
                case (state_reg)
                    IDLE:    state_reg <= (data == 8'hF0) ? BRK :
                                          (data == 8'hE0) ? EXT : IDLE;
                    EXT:     state_reg <= (data == 8'hF0) ? EXT_BRK : IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
            for (int i = 0; i < DEPTH; i++)
                slot_reg[i] <= slot_next[i];
            held_cnt    <= cnt_next;
            keycode     <= keycode_next;
            note_on     <= (cnt_next != 4'd0);
            note_change <= (keycode_next != keycode);
            overflow    <= press_shift && full;
        end
    end

endmodule
